// File: rtl/keypad_axil_pkg.sv
// Shared definitions for the keypad AXI4-Lite slave.
//   - word offsets of the four registers (address bits [3:2])
//   - scan FSM state encoding
//   - AXI OKAY response code
//   - first_low(): index of the lowest active-low bit in a column vector
package keypad_axil_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_KEYCODE = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        SCAN_IDLE   = 2'd0,
        SCAN_DRIVE  = 2'd1,
        SCAN_SAMPLE = 2'd2,
        SCAN_EVAL   = 2'd3
    } scan_state_e;

    // Lowest-numbered column pulled low; only meaningful when v_n != 4'hF.
    function automatic logic [1:0] first_low(input logic [3:0] v_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!v_n[3 - i]) idx = 2'(3 - i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with sweep-based debounce.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   scan_en_i       run the scan; low parks the FSM in IDLE (rows released)
//   kp_col_ni       column sense, active low, asynchronous to clk_i
//   kp_row_no       row drive, active low, one-hot while scanning
//   pressed_o       committed key-down state
//   code_o          committed key code (row*4+col), kept after release
//   event_o         one-cycle pulse when a new press/code is committed
module keypad_scanner
    import keypad_axil_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scan_en_i,
    input  logic [3:0] kp_col_ni,
    output logic [3:0] kp_row_no,
    output logic       pressed_o,
    output logic [3:0] code_o,
    output logic       event_o
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT + 1);

    scan_state_e      state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_meta_q, col_sync_q;
    logic             cand_vld_q, cand_vld_d;
    logic [3:0]       cand_code_q, cand_code_d;
    logic             prev_vld_q, prev_vld_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             pressed_q, pressed_d;
    logic [3:0]       code_q, code_d;
    logic             event_q, event_d;
    logic             same_cand;
    logic [DB_W-1:0]  cnt_nx;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        div_d       = div_q;
        cand_vld_d  = cand_vld_q;
        cand_code_d = cand_code_q;
        prev_vld_d  = prev_vld_q;
        prev_code_d = prev_code_q;
        db_cnt_d    = db_cnt_q;
        pressed_d   = pressed_q;
        code_d      = code_q;
        event_d     = 1'b0;
        // "No key" sweeps compare equal regardless of the stale code field.
        same_cand   = (cand_vld_q == prev_vld_q) && (!cand_vld_q || (cand_code_q == prev_code_q));
        cnt_nx      = db_cnt_q;

        case (state_q)
            SCAN_IDLE: begin
                state_d    = SCAN_DRIVE;
                row_d      = 2'd0;
                div_d      = '0;
                cand_vld_d = 1'b0;
            end
            SCAN_DRIVE: begin
                if (div_q == DIV_W'(SCAN_DIV - 1)) state_d = SCAN_SAMPLE;
                else                               div_d   = div_q + 1'b1;
            end
            SCAN_SAMPLE: begin
                // Rows are visited in ascending order, so the first hit of a
                // sweep is the lowest row; first_low picks the lowest column.
                if (!cand_vld_q && (col_sync_q != 4'hF)) begin
                    cand_vld_d  = 1'b1;
                    cand_code_d = {row_q, first_low(col_sync_q)};
                end
                if (row_q == 2'd3) begin
                    state_d = SCAN_EVAL;
                end else begin
                    state_d = SCAN_DRIVE;
                    row_d   = row_q + 2'd1;
                    div_d   = '0;
                end
            end
            SCAN_EVAL: begin
                if (!same_cand)                        cnt_nx = DB_W'(1);
                else if (db_cnt_q != DB_W'(DEBOUNCE_CNT)) cnt_nx = db_cnt_q + 1'b1;
                db_cnt_d    = cnt_nx;
                prev_vld_d  = cand_vld_q;
                prev_code_d = cand_code_q;
                if (cnt_nx == DB_W'(DEBOUNCE_CNT)) begin
                    if (cand_vld_q && (!pressed_q || (cand_code_q != code_q))) begin
                        pressed_d = 1'b1;
                        code_d    = cand_code_q;
                        event_d   = 1'b1;
                    end else if (!cand_vld_q && pressed_q) begin
                        pressed_d = 1'b0;
                    end
                end
                state_d    = SCAN_DRIVE;
                row_d      = 2'd0;
                div_d      = '0;
                cand_vld_d = 1'b0;
            end
            default: state_d = SCAN_IDLE;
        endcase

        if (!scan_en_i) state_d = SCAN_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SCAN_IDLE;
            row_q       <= 2'd0;
            div_q       <= '0;
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            cand_vld_q  <= 1'b0;
            cand_code_q <= 4'd0;
            prev_vld_q  <= 1'b0;
            prev_code_q <= 4'd0;
            db_cnt_q    <= '0;
            pressed_q   <= 1'b0;
            code_q      <= 4'd0;
            event_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            div_q       <= div_d;
            col_meta_q  <= kp_col_ni;
            col_sync_q  <= col_meta_q;
            cand_vld_q  <= cand_vld_d;
            cand_code_q <= cand_code_d;
            prev_vld_q  <= prev_vld_d;
            prev_code_q <= prev_code_d;
            db_cnt_q    <= db_cnt_d;
            pressed_q   <= pressed_d;
            code_q      <= code_d;
            event_q     <= event_d;
        end
    end

    always_comb begin
        kp_row_no = 4'hF;
        if ((state_q == SCAN_DRIVE) || (state_q == SCAN_SAMPLE)) kp_row_no[row_q] = 1'b0;
    end

    assign pressed_o = pressed_q;
    assign code_o    = code_q;
    assign event_o   = event_q;

endmodule

// File: rtl/keypad_axil_slave.sv
// AXI4-Lite slave front end for the 4x4 keypad scanner.
// Registers (byte offset): 0x0 CTRL {irq_en, scan_en}, 0x4 STATUS
// {pressed RO, key_event W1C}, 0x8 KEYCODE [3:0] RO, 0xC SCRATCH RW.
// Ports: s00_axi_* AXI4-Lite slave (aclk / async active-low aresetn),
//        kp_row_n row drive (active low), kp_col_n column sense (active low),
//        kp_irq (only with KEYPAD_IRQ_EN) registered key_event & irq_en.
// Build option: define KEYPAD_IRQ_EN to add kp_irq and CTRL[1].
module keypad_axil_slave
    import keypad_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned SCAN_DIV           = 1000,
    parameter int unsigned DEBOUNCE_CNT       = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [3:0]                      kp_row_n,
    input  logic [3:0]                      kp_col_n
`ifdef KEYPAD_IRQ_EN
    ,
    output logic                            kp_irq
`endif
);

    logic        wr_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
    logic [31:0] rdata_q, rd_val;
    logic        scan_en_q, scan_en_d;
    logic        irq_en_q, irq_en_d;
    logic        key_event_q, key_event_d;
    logic [31:0] scratch_q, scratch_d;
    logic        w1c;
    logic        kp_pressed, kp_evt;
    logic [3:0]  kp_code;
    logic        unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scan (
        .clk_i     (s00_axi_aclk),
        .rst_ni    (s00_axi_aresetn),
        .scan_en_i (scan_en_q),
        .kp_col_ni (kp_col_n),
        .kp_row_no (kp_row_n),
        .pressed_o (kp_pressed),
        .code_o    (kp_code),
        .event_o   (kp_evt)
    );

    // Register writes land on the edge that closes the awready/wready pulse.
    always_comb begin
        scan_en_d = scan_en_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        w1c       = 1'b0;
        if (wr_rdy_q) begin
            case (s00_axi_awaddr[3:2])
                ADDR_CTRL: begin
                    if (s00_axi_wstrb[0]) begin
                        scan_en_d = s00_axi_wdata[0];
`ifdef KEYPAD_IRQ_EN
                        irq_en_d  = s00_axi_wdata[1];
`endif
                    end
                end
                ADDR_STATUS: w1c = s00_axi_wstrb[0] & s00_axi_wdata[0];
                ADDR_SCRATCH: begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (s00_axi_wstrb[b]) scratch_d[8*b +: 8] = s00_axi_wdata[8*b +: 8];
                    end
                end
                default: ;
            endcase
        end
        // Hardware set beats a simultaneous software clear.
        key_event_d = kp_evt | (key_event_q & ~w1c);
    end

    always_comb begin
        rd_val = '0;
        case (s00_axi_araddr[3:2])
            ADDR_CTRL:    rd_val = {30'd0, irq_en_q, scan_en_q};
            ADDR_STATUS:  rd_val = {30'd0, kp_pressed, key_event_q};
            ADDR_KEYCODE: rd_val = {28'd0, kp_code};
            ADDR_SCRATCH: rd_val = scratch_q;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_rdy_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            ar_rdy_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            scan_en_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            key_event_q <= 1'b0;
            scratch_q   <= '0;
        end else begin
            // The !*_rdy_q terms keep each ready to a single-cycle pulse.
            wr_rdy_q <= s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !wr_rdy_q;
            if (wr_rdy_q)            bvalid_q <= 1'b1;
            else if (s00_axi_bready) bvalid_q <= 1'b0;

            ar_rdy_q <= s00_axi_arvalid && !rvalid_q && !ar_rdy_q;
            if (ar_rdy_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            scan_en_q   <= scan_en_d;
            irq_en_q    <= irq_en_d;
            key_event_q <= key_event_d;
            scratch_q   <= scratch_d;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic kp_irq_q;
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) kp_irq_q <= 1'b0;
        else                  kp_irq_q <= key_event_q & irq_en_q;
    end
    assign kp_irq = kp_irq_q;
`endif

    assign s00_axi_awready = wr_rdy_q;
    assign s00_axi_wready  = wr_rdy_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = ar_rdy_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_keypad_axil_slave.sv
module tb_keypad_axil_slave;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 2;
    // Long enough for any partial sweep plus DEBOUNCE_CNT full sweeps.
    localparam int SETTLE = (DEBOUNCE_CNT + 3) * (4 * (SCAN_DIV + 1) + 1);
`ifdef KEYPAD_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk, aresetn;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [3:0]  kp_row_n, kp_col_n;
    logic        kp_irq;
    logic [15:0] keys;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the register map
    logic        m_scan, m_irq, m_event, m_pressed;
    logic [3:0]  m_code;
    logic [31:0] m_scratch;

    keypad_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .SCAN_DIV           (SCAN_DIV),
        .DEBOUNCE_CNT       (DEBOUNCE_CNT)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .kp_row_n        (kp_row_n),
        .kp_col_n        (kp_col_n)
`ifdef KEYPAD_IRQ_EN
        ,
        .kp_irq          (kp_irq)
`endif
    );

`ifndef KEYPAD_IRQ_EN
    assign kp_irq = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key connects its row line to its column line.
    always_comb begin
        kp_col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!kp_row_n[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4 + c]) kp_col_n[c] = 1'b0;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lowest_key(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return 4'(i);
        return 4'd0;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_irq, m_scan};
            2'd1:    return {30'd0, m_pressed, m_event};
            2'd2:    return {28'd0, m_code};
            default: return m_scratch;
        endcase
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a)
            2'd0: if (s[0]) begin
                      m_scan = d[0];
                      if (HAS_IRQ) m_irq = d[1];
                  end
            2'd1: if (s[0] && d[0]) m_event = 1'b0;
            2'd3: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        m_scan = 0; m_irq = 0; m_event = 0; m_pressed = 0; m_code = 0; m_scratch = 0;
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (awready && wready) got = 1;
        end
        check("aw_w_handshake", 32'(got), 32'd1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit got = 0;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (arready) got = 1;
        end
        check("ar_handshake", 32'(got), 32'd1);
        @(negedge clk);
        arvalid = 0;
        check("rvalid", 32'(rvalid), 32'd1);
        check("rresp", 32'(rresp), 32'd0);
        d = rdata;
        @(negedge clk);
    endtask

    task automatic settle_keys(input logic [15:0] k);
        keys = k;
        repeat (SETTLE) @(negedge clk);
        if (k != 16'd0) begin
            if (!m_pressed || (lowest_key(k) != m_code)) m_event = 1'b1;
            m_code    = lowest_key(k);
            m_pressed = 1'b1;
        end else begin
            m_pressed = 1'b0;
        end
    endtask

    task automatic check_irq();
`ifdef KEYPAD_IRQ_EN
        @(negedge clk);
        check("kp_irq", 32'(kp_irq), 32'(m_event & m_irq));
`endif
    endtask

    initial begin
        logic [31:0] rd, d1, d2;
        logic [1:0]  a;
        logic [3:0]  s, k;
        logic [15:0] kk;
        bit          got;
        int          evals;
        bit          seen;

        aresetn = 0; keys = 0;
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_row",     32'(kp_row_n), 32'hF);
        check("rst_irq",     32'(kp_irq),  32'd0);
        aresetn = 1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check("rst_reg", rd, 32'd0);
        end

        // Scratch full and byte-lane writes
        axi_write(4'hC, 32'hA5A5_1234, 4'hF); model_write(2'd3, 32'hA5A5_1234, 4'hF);
        axi_read(4'hC, rd);
        check("scratch_full", rd, 32'hA5A5_1234);
        axi_write(4'hC, 32'h0000_00FF, 4'b0001); model_write(2'd3, 32'h0000_00FF, 4'b0001);
        axi_read(4'hC, rd);
        check("scratch_strb", rd, 32'hA5A5_12FF);

        // Random writes/reads across the map, including RO fields
        for (int i = 0; i < 12; i++) begin
            a = 2'($urandom_range(0, 3)); d1 = $urandom; s = 4'($urandom_range(0, 15));
            axi_write({a, 2'b00}, d1, s); model_write(a, d1, s);
            a = 2'($urandom_range(0, 3));
            axi_read({a, 2'b00}, rd);
            check("rand_reg", rd, exp_reg(a));
        end
        axi_write(4'h0, 32'd0, 4'hF); model_write(2'd0, 32'd0, 4'hF);

        // AW ahead of W, then back-pressured response
        d1 = $urandom; d2 = ~d1;
        @(negedge clk);
        awaddr = 4'hC; wdata = d1; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 0;
        repeat (3) begin
            @(negedge clk);
            check("aw_only_awready", 32'(awready), 32'd0);
        end
        wvalid = 1;
        @(negedge clk);
        check("split_awready", 32'(awready), 32'd1);
        check("split_wready",  32'(wready),  32'd1);
        @(negedge clk);
        model_write(2'd3, d1, 4'hF);
        check("split_pulse_end", 32'(awready), 32'd0);
        wdata = d2;
        repeat (5) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("no_second_accept", 32'(awready), 32'd0);
        end
        bready = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (awready) got = 1;
        end
        check("second_accept", 32'(got), 32'd1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        model_write(2'd3, d2, 4'hF);
        @(negedge clk);
        axi_read(4'hC, rd);
        check("second_data", rd, m_scratch);

        // Row 2 / column 1 press and release
        axi_write(4'h0, 32'd1, 4'hF); model_write(2'd0, 32'd1, 4'hF);
        settle_keys(16'h0200);
        axi_read(4'h8, rd); check("keycode_9", rd, 32'd9);
        axi_read(4'h4, rd); check("status_press", rd, 32'h3);
        check_irq();
        settle_keys(16'h0000);
        axi_read(4'h4, rd); check("status_release", rd, 32'h1);
        axi_read(4'h8, rd); check("keycode_kept", rd, 32'd9);
        axi_write(4'h4, 32'd1, 4'hF); model_write(2'd1, 32'd1, 4'hF);
        axi_read(4'h4, rd); check("status_w1c", rd, 32'h0);

        // Glitch shorter than a sweep
        repeat ($urandom_range(0, 20)) @(negedge clk);
        keys = 16'h0200;
        repeat ($urandom_range(1, 15)) @(negedge clk);
        keys = 16'h0000;
        repeat (SETTLE) @(negedge clk);
        axi_read(4'h4, rd); check("status_glitch", rd, 32'h0);

        // Random multi-key presses, changing code without a release in between
        for (int i = 0; i < 4; i++) begin
            axi_write(4'h4, 32'd1, 4'hF); model_write(2'd1, 32'd1, 4'hF);
            kk = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if (kk == 16'd0) kk = 16'(1 << $urandom_range(0, 15));
            settle_keys(kk);
            axi_read(4'h8, rd); check("rand_keycode", rd, exp_reg(2'd2));
            axi_read(4'h4, rd); check("rand_status", rd, exp_reg(2'd1));
        end
        settle_keys(16'h0000);
        axi_read(4'h4, rd); check("rand_release", rd, exp_reg(2'd1));

        // W1C landing in the same cycle as a new key event
        axi_write(4'h4, 32'd1, 4'hF); model_write(2'd1, 32'd1, 4'hF);
        axi_write(4'h0, 32'd0, 4'hF); model_write(2'd0, 32'd0, 4'hF);
        k = 4'($urandom_range(0, 15));
        keys = 16'(1 << k);
        axi_write(4'h0, 32'd3, 4'hF); model_write(2'd0, 32'd3, 4'hF);
        axi_read(4'h0, rd); check("ctrl_irq_bit", rd, exp_reg(2'd0));
        evals = 0; seen = 0;
        for (int i = 0; i < 300 && evals < DEBOUNCE_CNT; i++) begin
            @(negedge clk);
            if (kp_row_n == 4'hF) begin
                if (seen) evals++;
                seen = 0;
            end else begin
                seen = 1;
            end
        end
        check("eval_seen", 32'(evals), 32'(DEBOUNCE_CNT));
        awaddr = 4'h4; wdata = 32'd1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk);
        check("w1c_align", 32'(awready), 32'd1);
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("w1c_bvalid", 32'(bvalid), 32'd1);
        m_event = 1; m_pressed = 1; m_code = k;
        axi_read(4'h4, rd); check("set_wins", rd, 32'h3);
        axi_read(4'h8, rd); check("set_code", rd, 32'(k));
        check_irq();
        axi_write(4'h4, 32'd1, 4'hF); model_write(2'd1, 32'd1, 4'hF);
        axi_read(4'h4, rd); check("later_w1c", rd, 32'h2);
        check_irq();

        // Reset while a read response is stalled
        @(negedge clk);
        araddr = 4'hC; arvalid = 1; rready = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (arready) got = 1;
        end
        check("stall_ar", 32'(got), 32'd1);
        @(negedge clk);
        arvalid = 0;
        repeat (3) begin
            @(negedge clk);
            check("stall_rvalid", 32'(rvalid), 32'd1);
            check("stall_rdata", rdata, m_scratch);
        end
        aresetn = 0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_row", 32'(kp_row_n), 32'hF);
        check("mid_rst_irq", 32'(kp_irq), 32'd0);
        keys = 0;
        model_reset();
        repeat (2) @(negedge clk);
        aresetn = 1; rready = 1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check("post_rst_reg", rd, exp_reg(2'(i)));
        end
        check("post_rst_row", 32'(kp_row_n), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
